// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (HEADER, CMD, ARG, SUM, TAIL) from a UART byte stream.
// Publishes validated CMD/ARG with a one-cycle strobe and reports bad or stalled frames.
module uart_cmd_parser #(
  parameter logic [7:0]  Header  = 8'hA5,
  parameter logic [7:0]  Tail    = 8'h5A,
  parameter int unsigned Timeout = 1250000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_flag_i,
  output logic [7:0] cmd_o,
  output logic [7:0] arg_o,
  output logic       cmd_valid_o,
  output logic       err_flag_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  localparam logic [1:0] ErrSum     = 2'd1;
  localparam logic [1:0] ErrTail    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StGetCmd,
    StGetArg,
    StGetSum,
    StGetTail
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cmd_buf_q, cmd_buf_d;
  logic [7:0]      arg_buf_q, arg_buf_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      arg_q, arg_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            err_flag_q, err_flag_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [7:0] sum;
  logic       timeout_hit;

  // Carry is intentionally dropped: checksum is mod 256.
  assign sum         = cmd_buf_q + arg_buf_q;
  assign timeout_hit = (state_q != StIdle) && !rx_flag_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (rx_flag_i || (state_q == StIdle) || timeout_hit) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_buf_d   = cmd_buf_q;
    arg_buf_d   = arg_buf_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    cmd_valid_d = 1'b0;
    err_flag_d  = 1'b0;
    err_code_d  = err_code_q;

    if (rx_flag_i) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data_i == Header) begin
            state_d = StGetCmd;
          end
        end
        // A Header-valued byte here is payload, not a resync.
        StGetCmd: begin
          cmd_buf_d = rx_data_i;
          state_d   = StGetArg;
        end
        StGetArg: begin
          arg_buf_d = rx_data_i;
          state_d   = StGetSum;
        end
        StGetSum: begin
          if (rx_data_i == sum) begin
            state_d = StGetTail;
          end else begin
            state_d    = StIdle;
            err_flag_d = 1'b1;
            err_code_d = ErrSum;
          end
        end
        StGetTail: begin
          state_d = StIdle;
          if (rx_data_i == Tail) begin
            cmd_d       = cmd_buf_q;
            arg_d       = arg_buf_q;
            cmd_valid_d = 1'b1;
          end else begin
            err_flag_d = 1'b1;
            err_code_d = ErrTail;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (timeout_hit) begin
      state_d    = StIdle;
      err_flag_d = 1'b1;
      err_code_d = ErrTimeout;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cmd_buf_q   <= 8'h00;
      arg_buf_q   <= 8'h00;
      cmd_q       <= 8'h00;
      arg_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_code_q  <= 2'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_buf_q   <= cmd_buf_d;
      arg_buf_q   <= arg_buf_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      cmd_valid_q <= cmd_valid_d;
      err_flag_q  <= err_flag_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_o       = cmd_q;
  assign arg_o       = arg_q;
  assign cmd_valid_o = cmd_valid_q;
  assign err_flag_o  = err_flag_q;
  assign err_code_o  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frame-level reference model checked every cycle,
// directed frames with literal expectations, then randomized frames/gaps/resets.
module tb_uart_cmd_parser;

  localparam int unsigned To = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_flag = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] cmd, arg;
  logic       cmd_valid, err_flag;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .Header (8'hA5),
    .Tail   (8'h5A),
    .Timeout(To)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_data_i  (rx_data),
    .rx_flag_i  (rx_flag),
    .cmd_o      (cmd),
    .arg_o      (arg),
    .cmd_valid_o(cmd_valid),
    .err_flag_o (err_flag),
    .err_code_o (err_code)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the frame is the list of bytes accepted so far.
  logic [7:0] fq[$];
  int         idle = 0;
  logic [7:0] m_cmd = 0, m_arg = 0;
  logic       m_valid = 0, m_err = 0;
  logic [1:0] m_code = 0;

  task automatic model_step(input logic r, input logic f, input logic [7:0] d);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      fq.delete();
      idle   = 0;
      m_cmd  = 0;
      m_arg  = 0;
      m_code = 0;
    end else if (f) begin
      idle = 0;
      if (fq.size() == 0) begin
        if (d == 8'hA5) fq.push_back(d);
      end else if (fq.size() < 3) begin
        fq.push_back(d);
      end else if (fq.size() == 3) begin
        if (int'(d) == (int'(fq[1]) + int'(fq[2])) % 256) begin
          fq.push_back(d);
        end else begin
          fq.delete();
          m_err  = 1'b1;
          m_code = 2'd1;
        end
      end else begin
        if (d == 8'h5A) begin
          m_valid = 1'b1;
          m_cmd   = fq[1];
          m_arg   = fq[2];
        end else begin
          m_err  = 1'b1;
          m_code = 2'd2;
        end
        fq.delete();
      end
    end else if (fq.size() > 0) begin
      idle++;
      if (idle == To) begin
        fq.delete();
        idle   = 0;
        m_err  = 1'b1;
        m_code = 2'd3;
      end
    end
  endtask

  int valid_seen = 0;
  int err_seen   = 0;

  always @(posedge clk) begin
    model_step(rst, rx_flag, rx_data);
    #1;
    check("cmd", 32'(cmd), 32'(m_cmd));
    check("arg", 32'(arg), 32'(m_arg));
    check("cmd_valid", 32'(cmd_valid), 32'(m_valid));
    check("err_flag", 32'(err_flag), 32'(m_err));
    check("err_code", 32'(err_code), 32'(m_code));
    if (cmd_valid === 1'b1) valid_seen++;
    if (err_flag === 1'b1) err_seen++;
  end

  task automatic drive(input logic f, input logic [7:0] d);
    @(negedge clk);
    rx_flag = f;
    rx_data = d;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b1, d);
  endtask

  task automatic send5(input logic [7:0] a, b, c, d, e);
    send(a); send(b); send(c); send(d); send(e);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst     = 1'b1;
    rx_flag = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  int v0, e0;

  task automatic mark();
    v0 = valid_seen;
    e0 = err_seen;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_arg", 32'(arg), 32'h0);
    check("rst_code", 32'(err_code), 32'h0);
    check("rst_pulses", 32'(cmd_valid | err_flag), 32'h0);

    mark();
    send5(8'hA5, 8'h10, 8'h20, 8'h30, 8'h5A); drive(0, 0);
    check("f1_valid_cnt", 32'(valid_seen - v0), 32'd1);
    check("f1_err_cnt", 32'(err_seen - e0), 32'd0);
    check("f1_cmd", 32'(cmd), 32'h10);
    check("f1_arg", 32'(arg), 32'h20);

    send5(8'hA5, 8'hF0, 8'h20, 8'h10, 8'h5A); drive(0, 0);
    check("wrap_cmd", 32'(cmd), 32'hF0);
    check("wrap_arg", 32'(arg), 32'h20);

    mark();
    send5(8'hA5, 8'h10, 8'h20, 8'h31, 8'h5A); drive(0, 0);
    check("sum_err_cnt", 32'(err_seen - e0), 32'd1);
    check("sum_valid_cnt", 32'(valid_seen - v0), 32'd0);
    check("sum_code", 32'(err_code), 32'd1);
    check("sum_cmd_hold", 32'(cmd), 32'hF0);

    mark();
    send(8'h00); send5(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00); drive(0, 0);
    check("tail_err_cnt", 32'(err_seen - e0), 32'd1);
    check("tail_code", 32'(err_code), 32'd2);
    send5(8'hA5, 8'h01, 8'h02, 8'h03, 8'h5A); drive(0, 0);
    check("resync_valid_cnt", 32'(valid_seen - v0), 32'd1);
    check("resync_cmd", 32'(cmd), 32'h01);
    check("resync_arg", 32'(arg), 32'h02);

    send5(8'hA5, 8'hA5, 8'hA5, 8'h4A, 8'h5A); drive(0, 0);
    check("hdr_data_cmd", 32'(cmd), 32'hA5);
    check("hdr_data_arg", 32'(arg), 32'hA5);

    mark();
    send(8'hA5); send(8'h10);
    idle_n(To);
    check("to_early", 32'(err_seen - e0), 32'd0);
    drive(0, 0);
    check("to_err_cnt", 32'(err_seen - e0), 32'd1);
    check("to_code", 32'(err_code), 32'd3);

    mark();
    send(8'hA5); send(8'h10);
    idle_n(To - 1);
    send(8'h20); send(8'h30); send(8'h5A); drive(0, 0);
    check("to_edge_err_cnt", 32'(err_seen - e0), 32'd0);
    check("to_edge_valid_cnt", 32'(valid_seen - v0), 32'd1);
    check("to_edge_cmd", 32'(cmd), 32'h10);

    mark();
    send(8'hA5); send(8'h10); send(8'h20);
    do_reset(1);
    send(8'h30); send(8'h5A); drive(0, 0);
    check("midrst_valid_cnt", 32'(valid_seen - v0), 32'd0);
    check("midrst_err_cnt", 32'(err_seen - e0), 32'd0);
    check("midrst_cmd", 32'(cmd), 32'h0);
    check("midrst_arg", 32'(arg), 32'h0);
    check("midrst_code", 32'(err_code), 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] fb[5];
      int kind;
      kind  = int'($urandom_range(0, 19));
      fb[0] = 8'hA5;
      fb[1] = 8'($urandom);
      fb[2] = 8'($urandom);
      fb[3] = fb[1] + fb[2];
      fb[4] = 8'h5A;
      if (kind == 0) fb[3] = fb[3] ^ 8'($urandom_range(1, 255));
      if (kind == 1) fb[4] = 8'($urandom);
      if (kind == 2) send(8'($urandom));
      if (kind == 3) fb[0] = 8'($urandom);
      for (int i = 0; i < 5; i++) begin
        send(fb[i]);
        if ($urandom_range(0, 29) == 0) idle_n(int'($urandom_range(To - 2, To + 2)));
        else if ($urandom_range(0, 3) == 0) idle_n(int'($urandom_range(1, 3)));
        if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 2)));
      end
    end
    idle_n(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
